// File: rtl/cache_response_packetizer_if.sv
// Read-result capture and response-flit link between the cache arbiter port,
// the response packetizer and the router output port.
interface cache_response_packetizer_if #(
    parameter int DATA_WIDTH            = 32,
    parameter int NETWORK_ADDRESS_WIDTH = 4,
    parameter int FIFO_DEPTH            = 4
);
    localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                             readReady;
    logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressIn;
    logic [DATA_WIDTH-1:0]            cacheDataIn;
    logic [DATA_WIDTH-1:0]            flitOut;
    logic                             flitValid;
    logic                             flitReady;
    logic                             overflow;
    logic [COUNT_WIDTH-1:0]           fifoCount;

    // master is the packetizer; slave is the arbiter/router environment
    modport master (
        input  readReady, requesterAddressIn, cacheDataIn, flitReady,
        output flitOut, flitValid, overflow, fifoCount
    );

    modport slave (
        output readReady, requesterAddressIn, cacheDataIn, flitReady,
        input  flitOut, flitValid, overflow, fifoCount
    );
endinterface

// File: rtl/cache_response_packetizer.sv
// Queues cache read results for one router port and emits each one as a
// two-flit response packet (header, then data) on a valid/ready link.
module cache_response_packetizer #(
    parameter int                             DATA_WIDTH            = 32,
    parameter int                             NETWORK_ADDRESS_WIDTH = 4,
    parameter logic [NETWORK_ADDRESS_WIDTH-1:0] LOCAL_ADDRESS       = '0,
    parameter int                             FIFO_DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    cache_response_packetizer_if.master rsp_if
);
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int COUNT_WIDTH = PTR_WIDTH + 1;
    localparam int ENTRY_WIDTH = NETWORK_ADDRESS_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    logic [ENTRY_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q;
    logic [PTR_WIDTH-1:0]   rd_ptr_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   overflow_q;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  hold_data_q;
    logic [DATA_WIDTH-1:0]  flit_q;
    logic                   flit_valid_q;

    logic                             fifo_nonempty;
    logic                             pop;
    logic                             push;
    logic [NETWORK_ADDRESS_WIDTH-1:0] head_dest;
    logic [DATA_WIDTH-1:0]            head_data;

    function automatic logic [DATA_WIDTH-1:0] make_header(
        input logic [NETWORK_ADDRESS_WIDTH-1:0] dest
    );
        logic [DATA_WIDTH-1:0] h;
        h = '0;
        h[DATA_WIDTH-1 -: 2]                                   = 2'b10;
        h[DATA_WIDTH-3 -: NETWORK_ADDRESS_WIDTH]               = dest;
        h[DATA_WIDTH-3-NETWORK_ADDRESS_WIDTH -: NETWORK_ADDRESS_WIDTH] = LOCAL_ADDRESS;
        return h;
    endfunction

    assign head_dest = mem_q[rd_ptr_q][ENTRY_WIDTH-1 -: NETWORK_ADDRESS_WIDTH];
    assign head_data = mem_q[rd_ptr_q][DATA_WIDTH-1:0];

    // A full FIFO still accepts a push on an edge that also pops; a push into
    // an empty FIFO is never bypassed to the FSM on the same edge.
    always_comb begin
        fifo_nonempty = (count_q != '0);
        pop           = fifo_nonempty &&
                        ((state_q == ST_IDLE) || ((state_q == ST_BODY) && rsp_if.flitReady));
        push          = rsp_if.readReady &&
                        ((count_q != COUNT_WIDTH'(FIFO_DEPTH)) || pop);
        count_d       = count_q;
        if (push && !pop) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end else if (pop && !push) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= {rsp_if.requesterAddressIn, rsp_if.cacheDataIn};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
            count_q <= count_d;
            if (rsp_if.readReady && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Flit outputs are registered; the header is formed while popping so
    // the destination need not be held separately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_data_q  <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        hold_data_q  <= head_data;
                        flit_q       <= make_header(head_dest);
                        flit_valid_q <= 1'b1;
                        state_q      <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (rsp_if.flitReady) begin
                        flit_q  <= hold_data_q;
                        state_q <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (rsp_if.flitReady) begin
                        if (pop) begin
                            hold_data_q <= head_data;
                            flit_q      <= make_header(head_dest);
                            state_q     <= ST_HEAD;
                        end else begin
                            flit_q       <= '0;
                            flit_valid_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    flit_q       <= '0;
                    flit_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_if.flitOut   = flit_q;
    assign rsp_if.flitValid = flit_valid_q;
    assign rsp_if.overflow  = overflow_q;
    assign rsp_if.fifoCount = count_q;
endmodule
